// File: rtl/if_defs_pkg.sv
//------------------------------------------------------------------------------
// Module  : if_defs (package)
// Brief   : Shared IF-stage definitions: default PC width, FSM encodings, PC step.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_defs;

    localparam int XLEN_DEFAULT = 32;
    localparam int PC_INC       = 4;

    typedef enum logic {
        IF_BOOT = 1'b0,
        IF_RUN  = 1'b1
    } if_state_t;

endpackage

`default_nettype wire

// File: rtl/if_btb.sv
//------------------------------------------------------------------------------
// Module  : if_btb
// Brief   : Direct-mapped branch target buffer with lookup, write and an
//           optional same-cycle write-to-lookup bypass (macro BTB_BYPASS_EN).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_btb #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    output logic            hit,
    output logic [XLEN-1:0] target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0] w_wr_tag;
    logic [XLEN-1:0]  w_wr_target;
    logic             w_arr_hit;
    logic             w_unused;

    assign w_lk_idx    = lookup_pc[IDX_W+1:2];
    assign w_lk_tag    = lookup_pc[XLEN-1:IDX_W+2];
    assign w_wr_idx    = wr_pc[IDX_W+1:2];
    assign w_wr_tag    = wr_pc[XLEN-1:IDX_W+2];
    assign w_wr_target = {wr_target[XLEN-1:2], 2'b00};
    assign w_unused    = ^{lookup_pc[1:0], wr_pc[1:0], wr_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= w_wr_target;
        end
    end

    assign w_arr_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

`ifdef BTB_BYPASS_EN
    logic w_bypass;
    assign w_bypass = wr_en && (w_wr_idx == w_lk_idx) && (w_wr_tag == w_lk_tag);
    assign hit      = w_arr_hit | w_bypass;
    assign target   = w_bypass  ? w_wr_target :
                      w_arr_hit ? r_target[w_lk_idx] : '0;
`else
    assign hit      = w_arr_hit;
    assign target   = w_arr_hit ? r_target[w_lk_idx] : '0;
`endif

endmodule

`default_nettype wire

// File: rtl/if_pc_gen.sv
//------------------------------------------------------------------------------
// Module  : if_pc_gen
// Brief   : IF-stage next-PC generator: PC register, BOOT/RUN FSM, next-PC mux
//           and BTB. Optional BTB write bypass via macro BTB_BYPASS_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_pc_gen
    import if_defs::*;
#(
    parameter int               XLEN        = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_prediction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            btb_wr_en,
    input  logic [XLEN-1:0] btb_wr_pc,
    input  logic [XLEN-1:0] btb_wr_target,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            btb_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);

    if_state_t        r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_pc_valid;
    logic [XLEN-1:0]  w_pc_next;
    logic [XLEN-1:0]  w_pc_inc;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_unused;

    if_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lookup_pc (r_pc),
        .wr_en     (btb_wr_en),
        .wr_pc     (btb_wr_pc),
        .wr_target (btb_wr_target),
        .hit       (btb_hit_o),
        .target    (pred_target_o)
    );

    assign pred_taken_o  = btb_hit_o & branch_prediction;
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_pc_inc      = r_pc + XLEN'(PC_INC);
    assign w_unused      = ^redirect_pc[1:0];

    // A redirect wins even in BOOT; otherwise BOOT simply holds the PC.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid) begin
            w_pc_next = w_redirect_pc;
        end else if (r_state == IF_RUN && !stall) begin
            w_pc_next = pred_taken_o ? pred_target_o : w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IF_BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            case (r_state)
                IF_BOOT: begin
                    r_state    <= IF_RUN;
                    r_pc_valid <= 1'b1;
                end
                IF_RUN: begin
                    r_state    <= IF_RUN;
                    r_pc_valid <= 1'b1;
                end
                default: begin
                    r_state    <= IF_BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign pc_valid_o = r_pc_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_pc_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_if_pc_gen
// Brief   : Directed scoreboard bench for if_pc_gen.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_prediction = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        btb_wr_en = 1'b0;
    logic [31:0] btb_wr_pc = '0;
    logic [31:0] btb_wr_target = '0;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        btb_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    if_pc_gen #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BTB_ENTRIES (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_prediction (branch_prediction),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .btb_wr_en         (btb_wr_en),
        .btb_wr_pc         (btb_wr_pc),
        .btb_wr_target     (btb_wr_target),
        .pc_o              (pc_o),
        .pc_valid_o        (pc_valid_o),
        .btb_hit_o         (btb_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        valid;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

`ifdef BTB_BYPASS_EN
    localparam logic        BYP_HIT = 1'b1;
    localparam logic [31:0] BYP_TGT = 32'h180;
`else
    localparam logic        BYP_HIT = 1'b0;
    localparam logic [31:0] BYP_TGT = 32'h0;
`endif

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge and queue what the next negedge must show.
    task automatic cyc(input logic r, input logic st, input logic bp,
                       input logic rv, input logic [31:0] rpc,
                       input logic we, input logic [31:0] wpc, input logic [31:0] wtgt,
                       input logic [31:0] epc, input logic ev, input logic eh,
                       input logic et, input logic [31:0] etgt);
        exp_t e;
        @(posedge clk);
        #1;
        cyc_n++;
        rst = r; stall = st; branch_prediction = bp;
        redirect_valid = rv; redirect_pc = rpc;
        btb_wr_en = we; btb_wr_pc = wpc; btb_wr_target = wtgt;
        e.cyc = cyc_n; e.pc = epc; e.valid = ev; e.hit = eh; e.taken = et; e.tgt = etgt;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_o",          e.cyc, pc_o,                  e.pc);
            chk("pc_valid_o",    e.cyc, {31'b0, pc_valid_o},   {31'b0, e.valid});
            chk("btb_hit_o",     e.cyc, {31'b0, btb_hit_o},    {31'b0, e.hit});
            chk("pred_taken_o",  e.cyc, {31'b0, pred_taken_o}, {31'b0, e.taken});
            chk("pred_target_o", e.cyc, pred_target_o,         e.tgt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   rst st bp rv rpc           we wpc    wtgt     | pc           v  hit tk tgt
        // reset and boot sequence
        cyc(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h0,        0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h0,        0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h0,        0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h0,        1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h4,        1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h8,        1, 0, 0, 32'h0);
        // install 0x10 -> 0x81 (target low bits dropped)
        cyc(0, 0, 1, 0, 32'h0,        1, 32'h10, 32'h81,   32'hC,        1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0,        0, 32'h0,  32'h0,    32'h10,       1, 1, 1, 32'h80);
        cyc(0, 0, 1, 1, 32'h10,       0, 32'h0,  32'h0,    32'h80,       1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h10,       1, 1, 0, 32'h80);
        // priority: redirect beats stall and predicted-taken
        cyc(0, 0, 1, 1, 32'h10,       0, 32'h0,  32'h0,    32'h14,       1, 0, 0, 32'h0);
        cyc(0, 1, 1, 1, 32'h203,      0, 32'h0,  32'h0,    32'h10,       1, 1, 1, 32'h80);
        cyc(0, 0, 0, 1, 32'h40,       0, 32'h0,  32'h0,    32'h200,      1, 0, 0, 32'h0);
        // stall hold and wrap-around
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h40,       1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h40,       1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h40,       1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'hFFFFFFFE, 0, 32'h0,  32'h0,    32'h40,       1, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'hFFFFFFFC, 1, 0, 0, 32'h0);
        // aliasing: 0x50 evicts 0x10 (same index)
        cyc(0, 0, 0, 1, 32'h10,       1, 32'h50, 32'h300,  32'h0,        1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h50,       0, 32'h0,  32'h0,    32'h10,       1, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'h10,       0, 32'h0,  32'h0,    32'h50,       1, 1, 0, 32'h300);
        // same-cycle write and lookup of 0x10
        cyc(0, 0, 0, 0, 32'h0,        1, 32'h10, 32'h180,  32'h10,       1, BYP_HIT, 0, BYP_TGT);
        cyc(0, 0, 0, 1, 32'h10,       0, 32'h0,  32'h0,    32'h14,       1, 0, 0, 32'h0);
        // mid-run reset clears BTB, redirect taken in BOOT
        cyc(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h10,       1, 1, 0, 32'h180);
        cyc(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,    32'h0,        0, 0, 0, 32'h0);
        cyc(0, 0, 1, 1, 32'h10,       0, 32'h0,  32'h0,    32'h0,        0, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0,        0, 32'h0,  32'h0,    32'h10,       1, 0, 0, 32'h0);
        cyc(0, 0, 1, 0, 32'h0,        0, 32'h0,  32'h0,    32'h14,       1, 0, 0, 32'h0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
